// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory fetch block.
package imem_pkg;

  localparam int LATENCY_MAX = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_e;

  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction word array: one write port, one registered read port that
// forms fetch pipeline stage 1 (read-enable plus hold).
module imem_ram
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_hold,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];
  logic [DATA_W-1:0] rd_data_r;

  // Array write; contents survive reset, out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && addr_in_range(32'(wr_addr), 32'(DEPTH))) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register: frozen on hold, zero for bubbles and out-of-range reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (rd_hold) begin
      rd_data_r <= rd_data_r;
    end else if (rd_en && addr_in_range(32'(rd_addr), 32'(DEPTH))) begin
      rd_data_r <= mem_r[rd_addr];
    end else begin
      rd_data_r <= {DATA_W{1'b0}};
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/imem_fetch.sv
// Instruction memory with a LATENCY-stage fetch pipeline, backpressure and a
// program-load port that drains outstanding fetches before taking over.
module imem_fetch
  import imem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } rsp_t;

  if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("imem_fetch: LATENCY out of range");
  end

  state_e            state_r, state_s;
  logic              stall_s, accept_s, busy_s;
  logic              req_ready_s, ld_ready_s;
  logic              s1_valid_r, s1_err_r;
  logic [ADDR_W-1:0] s1_addr_r;
  logic [DATA_W-1:0] ram_data_s;
  rsp_t              pipe_s [LATENCY];

  assign stall_s   = pipe_s[LATENCY-1].valid && !rsp_ready;
  assign req_ready = rst_n && req_ready_s;
  assign ld_ready  = rst_n && ld_ready_s;
  assign accept_s  = req_valid && req_ready;

  imem_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ld_valid && ld_ready),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_en   (accept_s),
    .rd_hold (stall_s),
    .rd_addr (req_addr),
    .rd_data (ram_data_s)
  );

  // Stage-1 request tag travelling alongside the RAM read register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_addr_r  <= {ADDR_W{1'b0}};
      s1_err_r   <= 1'b0;
    end else if (stall_s) begin
      s1_valid_r <= s1_valid_r;
      s1_addr_r  <= s1_addr_r;
      s1_err_r   <= s1_err_r;
    end else begin
      s1_valid_r <= accept_s;
      s1_addr_r  <= accept_s ? req_addr : {ADDR_W{1'b0}};
      s1_err_r   <= accept_s && !addr_in_range(32'(req_addr), 32'(DEPTH));
    end
  end

  assign pipe_s[0] = '{valid: s1_valid_r, data: ram_data_s, addr: s1_addr_r, err: s1_err_r};

  for (genvar k = 1; k < LATENCY; k++) begin : g_stage
    rsp_t stage_r;
    // Delay stage; the whole pipeline freezes together on stall.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stage_r <= '{valid: 1'b0, data: {DATA_W{1'b0}}, addr: {ADDR_W{1'b0}}, err: 1'b0};
      end else if (stall_s) begin
        stage_r <= stage_r;
      end else begin
        stage_r <= pipe_s[k-1];
      end
    end
    assign pipe_s[k] = stage_r;
  end

  assign rsp_valid = pipe_s[LATENCY-1].valid;
  assign rsp_data  = pipe_s[LATENCY-1].data;
  assign rsp_addr  = pipe_s[LATENCY-1].addr;
  assign rsp_err   = pipe_s[LATENCY-1].err;

  // Any fetch still in a stage or waiting at the output.
  always_comb begin
    busy_s = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      busy_s = busy_s | pipe_s[k].valid;
    end
  end

  // Mode register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Mode transitions and handshake readies; a load request always wins.
  always_comb begin
    state_s     = state_r;
    req_ready_s = 1'b0;
    ld_ready_s  = 1'b0;
    case (state_r)
      RUN: begin
        req_ready_s = !stall_s && !ld_valid;
        if (ld_valid) state_s = DRAIN;
        else          state_s = RUN;
      end
      DRAIN: begin
        if (!busy_s) state_s = LOAD;
        else         state_s = DRAIN;
      end
      LOAD: begin
        ld_ready_s = 1'b1;
        if (!ld_valid) state_s = RUN;
        else           state_s = LOAD;
      end
      default: begin
        state_s = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: instance 0 uses LATENCY=1/DEPTH=256,
// instance 1 uses LATENCY=3/DEPTH=200; a reference model checks every response.
module tb_imem_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [7:0]  req_addr  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic [7:0]  rsp_addr  [2];
  logic        rsp_err   [2];
  logic        ld_valid  [2];
  logic        ld_ready  [2];
  logic [7:0]  ld_addr   [2];
  logic [31:0] ld_data   [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_fetch #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_addr(rsp_addr[0]), .rsp_err(rsp_err[0]),
    .ld_valid(ld_valid[0]), .ld_ready(ld_ready[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0])
  );

  imem_fetch #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .LATENCY(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_addr(rsp_addr[1]), .rsp_err(rsp_err[1]),
    .ld_valid(ld_valid[1]), .ld_ready(ld_ready[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int dep_of(input int d);
    return (d == 0) ? 256 : 200;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=timeout required=handshake", name);
  endtask

  // Reference model: expected-response queues, memory image, stall counts.
  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        err;
    int          cyc;
    int          stl;
  } exp_t;

  exp_t        expq [2][$];
  logic [31:0] mem_m [2][256];
  int          stall_cnt [2] = '{0, 0};
  int          rx_cnt [2] = '{0, 0};
  logic        hold_p [2] = '{1'b0, 1'b0};
  logic [31:0] prev_data [2];
  logic [7:0]  prev_addr [2];
  logic        prev_err [2];

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        expq[d].delete();
        hold_p[d] = 1'b0;
      end else begin
        if (hold_p[d]) begin
          chk("hold_valid", rsp_valid[d], 32'd1);
          chk("hold_data", rsp_data[d], prev_data[d]);
          chk("hold_addr", rsp_addr[d], prev_addr[d]);
          chk("hold_err", rsp_err[d], prev_err[d]);
        end
        if (rsp_valid[d] && rsp_ready[d]) begin
          if (expq[d].size() == 0) begin
            chk("spurious_rsp", 32'(expq[d].size()), 32'd1);
          end else begin
            e = expq[d].pop_front();
            chk("rsp_data", rsp_data[d], e.data);
            chk("rsp_addr", rsp_addr[d], e.addr);
            chk("rsp_err", rsp_err[d], e.err);
            chk("rsp_latency", 32'(cyc - e.cyc), 32'(lat_of(d) + stall_cnt[d] - e.stl));
            rx_cnt[d]++;
          end
        end
        if (rsp_valid[d] && !rsp_ready[d]) begin
          chk("req_ready_in_stall", req_ready[d], 32'd0);
          stall_cnt[d]++;
          hold_p[d]    = 1'b1;
          prev_data[d] = rsp_data[d];
          prev_addr[d] = rsp_addr[d];
          prev_err[d]  = rsp_err[d];
        end else begin
          hold_p[d] = 1'b0;
        end
        if (req_valid[d] && req_ready[d]) begin
          e.addr = req_addr[d];
          e.err  = (int'(req_addr[d]) >= dep_of(d));
          e.data = e.err ? 32'd0 : mem_m[d][req_addr[d]];
          e.cyc  = cyc;
          e.stl  = stall_cnt[d];
          expq[d].push_back(e);
        end
        if (ld_valid[d] && ld_ready[d] && int'(ld_addr[d]) < dep_of(d)) begin
          mem_m[d][ld_addr[d]] = ld_data[d];
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int d, input logic [7:0] base, input int n);
    logic ok;
    for (int i = 0; i < n; i++) begin
      req_valid[d] = 1'b1;
      req_addr[d]  = base + 8'(i);
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (req_ready[d]) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) timeout_fail("fetch_wait");
      sync();
    end
    req_valid[d] = 1'b0;
  endtask

  task automatic load(input int d, input logic [7:0] a, input logic [31:0] v);
    logic ok;
    ld_valid[d] = 1'b1;
    ld_addr[d]  = a;
    ld_data[d]  = v;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ld_ready[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("load_wait");
    sync();
  endtask

  task automatic ld_done(input int d);
    ld_valid[d] = 1'b0;
    sync();
  endtask

  task automatic wait_rsp(input int d, output int n);
    n = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      n++;
      if (rsp_valid[d]) return;
    end
    timeout_fail("rsp_wait");
  endtask

  task automatic wait_idle(input int d);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (expq[d].size() == 0 && !rsp_valid[d]) return;
    end
    timeout_fail("idle_wait");
  endtask

  initial begin
    #60000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int rx0;
    logic [31:0] hd;
    logic [7:0]  ha;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_addr[d] = 8'd0; rsp_ready[d] = 1'b1;
      ld_valid[d] = 1'b0; ld_addr[d] = 8'd0; ld_data[d] = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_rsp_valid", rsp_valid[d], 32'd0);
      chk("rst_rsp_data", rsp_data[d], 32'd0);
      chk("rst_rsp_addr", rsp_addr[d], 32'd0);
      chk("rst_rsp_err", rsp_err[d], 32'd0);
      chk("rst_req_ready", req_ready[d], 32'd0);
      chk("rst_ld_ready", ld_ready[d], 32'd0);
    end
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("run_req_ready", req_ready[0], 32'd1);
    chk("run_ld_ready", ld_ready[0], 32'd0);
    sync();

    // LATENCY=1: load 75/76 then fetch them back-to-back.
    req_valid[0] = 1'b1; req_addr[0] = 8'd5;
    ld_valid[0] = 1'b1; ld_addr[0] = 8'd75; ld_data[0] = 32'd3000;
    @(negedge clk);
    chk("load_wins_req_ready", req_ready[0], 32'd0);
    chk("load_wins_ld_ready", ld_ready[0], 32'd0);
    sync();
    req_valid[0] = 1'b0;
    load(0, 8'd75, 32'd3000);
    load(0, 8'd76, 32'hDEADBEEF);
    ld_done(0);
    fork
      fetch(0, 8'd75, 2);
      begin
        @(negedge clk);
        wait_rsp(0, n);
        chk("l1_latency", 32'(n), 32'd1);
        chk("l1_data0", rsp_data[0], 32'd3000);
        chk("l1_addr0", rsp_addr[0], 32'd75);
        chk("l1_err0", rsp_err[0], 32'd0);
        @(negedge clk);
        chk("l1_valid1", rsp_valid[0], 32'd1);
        chk("l1_data1", rsp_data[0], 32'hDEADBEEF);
        chk("l1_addr1", rsp_addr[0], 32'd76);
      end
    join
    sync();

    // LATENCY=3: program image, then 8 streaming fetches.
    for (int i = 0; i < 8; i++) load(1, 8'(10 + i), 32'h100 + 32'(i));
    load(1, 8'd75, 32'h1111);
    load(1, 8'd76, 32'h2222);
    load(1, 8'd199, 32'hABCD);
    ld_done(1);
    fork
      fetch(1, 8'd10, 8);
      begin
        @(negedge clk);
        wait_rsp(1, n);
        chk("l3_latency", 32'(n), 32'd3);
        for (int i = 0; i < 8; i++) begin
          if (i > 0) @(negedge clk);
          chk("l3_stream_valid", rsp_valid[1], 32'd1);
          chk("l3_stream_data", rsp_data[1], 32'h100 + 32'(i));
          chk("l3_stream_addr", rsp_addr[1], 32'(10 + i));
        end
      end
    join
    sync();

    // Backpressure: rsp_ready low for 4 cycles mid-stream.
    rx0 = rx_cnt[1];
    fork
      fetch(1, 8'd10, 8);
      begin
        repeat (5) @(negedge clk);
        sync();
        rsp_ready[1] = 1'b0;
        @(negedge clk);
        chk("bp_valid", rsp_valid[1], 32'd1);
        chk("bp_req_ready", req_ready[1], 32'd0);
        hd = rsp_data[1];
        ha = rsp_addr[1];
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_req_ready", req_ready[1], 32'd0);
          chk("bp_hold_data", rsp_data[1], hd);
          chk("bp_hold_addr", rsp_addr[1], 32'(ha));
        end
        sync();
        rsp_ready[1] = 1'b1;
      end
    join
    wait_idle(1);
    chk("bp_count", 32'(rx_cnt[1] - rx0), 32'd8);
    sync();

    // Out-of-range fetch and load with DEPTH=200.
    fetch(1, 8'd210, 1);
    wait_rsp(1, n);
    chk("oor_err", rsp_err[1], 32'd1);
    chk("oor_data", rsp_data[1], 32'd0);
    chk("oor_addr", rsp_addr[1], 32'd210);
    sync();
    load(1, 8'd210, 32'd5);
    ld_done(1);
    fetch(1, 8'd199, 1);
    wait_rsp(1, n);
    chk("top_data", rsp_data[1], 32'hABCD);
    chk("top_err", rsp_err[1], 32'd0);
    sync();
    fetch(1, 8'd210, 1);
    wait_rsp(1, n);
    chk("oor2_err", rsp_err[1], 32'd1);
    chk("oor2_data", rsp_data[1], 32'd0);
    sync();

    // Load request with two fetches in flight: drain, then write 75.
    rx0 = rx_cnt[1];
    fetch(1, 8'd75, 2);
    ld_valid[1] = 1'b1; ld_addr[1] = 8'd75; ld_data[1] = 32'h7777;
    @(negedge clk);
    chk("drain_ld_ready", ld_ready[1], 32'd0);
    chk("drain_req_ready", req_ready[1], 32'd0);
    sync();
    load(1, 8'd75, 32'h7777);
    chk("drain_delivered", 32'(rx_cnt[1] - rx0), 32'd2);
    ld_done(1);
    fetch(1, 8'd75, 1);
    wait_rsp(1, n);
    chk("new_data_75", rsp_data[1], 32'h7777);
    sync();

    // Reset with three fetches in flight.
    rsp_ready[1] = 1'b0;
    fetch(1, 8'd10, 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_gate_req_ready", req_ready[0], 32'd0);
    sync();
    rst_n = 1'b1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("post_rst_data", rsp_data[1], 32'd0);
    chk("post_rst_addr", rsp_addr[1], 32'd0);
    chk("post_rst_err", rsp_err[1], 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_no_rsp", rsp_valid[1], 32'd0);
      @(negedge clk);
    end
    sync();
    fetch(1, 8'd75, 1);
    wait_rsp(1, n);
    chk("retained_75", rsp_data[1], 32'h7777);
    sync();
    fetch(1, 8'd10, 1);
    wait_rsp(1, n);
    chk("retained_10", rsp_data[1], 32'h100);
    sync();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
